// File: rtl/stream_codec_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | codec_pkg : mode encoding, default LFSR taps and keystream step     |
// | Revision  : 1.0                                                     |
// +--------------------------------------------------------------------+
package codec_pkg;

  typedef enum logic {
    STATIC = 1'b0,
    ROLL   = 1'b1
  } codec_mode_e;

  localparam int              C_MAX_W         = 64;
  localparam logic [63:0]     C_TAPS_DEFAULT  = 64'hD800_0000_0000_0000;

  // Narrower keys are zero-extended; truncating the result yields the same shift
  function automatic logic [C_MAX_W-1:0] lfsr_next(
    input logic [C_MAX_W-1:0] key,
    input logic [C_MAX_W-1:0] taps
  );
    return {key[C_MAX_W-2:0], ^(key & taps)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_codec_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_codec_if : valid/ready/data beat channel                     |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
interface stream_codec_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/stream_codec_keygen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | codec_keygen : key register with load-over-advance priority         |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module codec_keygen
  import codec_pkg::*;
#(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] TAPS    = DATA_W'(C_TAPS_DEFAULT),
  parameter logic [DATA_W-1:0] KEY_RST = '0
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              key_load_i,
  input  wire logic [DATA_W-1:0] key_i,
  input  wire logic              mode_i,
  input  wire logic              advance_i,
  output logic      [DATA_W-1:0] key_o
);

  logic [DATA_W-1:0] r_key;
  codec_mode_e       r_mode;
  logic [DATA_W-1:0] w_key_next;

  assign w_key_next = DATA_W'(lfsr_next(C_MAX_W'(r_key), C_MAX_W'(TAPS)));
  assign key_o      = r_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key  <= KEY_RST;
      r_mode <= STATIC;
    end else if (key_load_i) begin
      r_key  <= key_i;
      r_mode <= codec_mode_e'(mode_i);
    end else if (advance_i && (r_mode == ROLL)) begin
      r_key  <= w_key_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_codec.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_codec : one-stage valid/ready XOR codec, static or LFSR key  |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
module stream_codec
  import codec_pkg::*;
#(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] TAPS    = DATA_W'(C_TAPS_DEFAULT),
  parameter logic [DATA_W-1:0] KEY_RST = '0,
  parameter int                CNT_W   = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              key_load_i,
  input  wire logic [DATA_W-1:0] key_i,
  input  wire logic              mode_i,
  stream_codec_if.slave          in_if,
  stream_codec_if.master         out_if,
  output logic      [CNT_W-1:0]  beat_cnt_o
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_key;
  logic              w_in_ready;
  logic              w_acc;

  // Combinational ready from downstream keeps a full beat per cycle
  assign w_in_ready   = !r_valid || out_if.ready;
  assign w_acc        = in_if.valid && w_in_ready;
  assign in_if.ready  = w_in_ready;
  assign out_if.valid = r_valid;
  assign out_if.data  = r_data;
  assign beat_cnt_o   = r_cnt;

  codec_keygen #(
    .DATA_W  (DATA_W),
    .TAPS    (TAPS),
    .KEY_RST (KEY_RST)
  ) u_keygen (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load_i (key_load_i),
    .key_i      (key_i),
    .mode_i     (mode_i),
    .advance_i  (w_acc),
    .key_o      (w_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_acc) begin
        r_data  <= in_if.data ^ w_key;
        r_valid <= 1'b1;
      end else if (out_if.ready) begin
        r_valid <= 1'b0;
      end
      // A load restarts the count even if a beat is taken in the same cycle
      if (key_load_i) begin
        r_cnt <= '0;
      end else if (w_acc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
